// File: rtl/ifetch_stage_if.sv
// ifetch_stage_if: instruction memory request/response bus.
// master = fetch stage, slave = instruction memory.
interface ifetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/ifetch_stage.sv
// ifetch_stage: fetch PC, imem handshake, one-entry hold buffer
// and the IF/ID register feeding decode.
module ifetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  StallF,
   input  logic                  FlushD,
   input  logic                  BranchTakenE,
   input  logic [31:0]           BranchTargetE,
   ifetch_stage_if.master        imem,
   output logic [31:0]           PCF,
   output logic [31:0]           InstrD,
   output logic [31:0]           PCPlus8D,
   output logic                  ValidD
);

   typedef enum logic [1:0] {
      S_REQ,
      S_HOLD,
      S_DISCARD
   } state_t;

   state_t      state_q;
   state_t      state_nx;
   logic [31:0] redir_pc;
   logic [31:0] redir_nx;
   logic [31:0] pcf_nx;
   logic [31:0] buf_instr;
   logic [31:0] buf_pc8;
   logic        buf_valid;
   logic        buf_valid_nx;
   logic        buf_load;
   logic        take_mem;
   logic        take_buf;

   assign imem.imem_req  = (state_q != S_HOLD);
   assign imem.imem_addr = PCF;

   always_comb begin
      state_nx     = state_q;
      pcf_nx       = PCF;
      redir_nx     = redir_pc;
      buf_valid_nx = buf_valid;
      buf_load     = 1'b0;
      take_mem     = 1'b0;
      take_buf     = 1'b0;
      unique case (state_q)
         S_REQ: begin
            if (BranchTakenE) begin
               buf_valid_nx = 1'b0;
               if (imem.imem_ready) begin
                  pcf_nx = BranchTargetE;
               end else begin
                  redir_nx = BranchTargetE;
                  state_nx = S_DISCARD;
               end
            end else if (FlushD) begin
               // returning word is dropped; PCF held so it is refetched
               pcf_nx = PCF;
            end else if (imem.imem_ready) begin
               pcf_nx = PCF + 32'd4;
               if (StallF) begin
                  buf_load     = 1'b1;
                  buf_valid_nx = 1'b1;
                  state_nx     = S_HOLD;
               end else begin
                  take_mem = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (BranchTakenE) begin
               buf_valid_nx = 1'b0;
               pcf_nx       = BranchTargetE;
               state_nx     = S_REQ;
            end else if (FlushD) begin
               // buffered word is squashed with IF/ID: rewind to refetch it
               buf_valid_nx = 1'b0;
               pcf_nx       = buf_pc8 - 32'd8;
               state_nx     = S_REQ;
            end else if (!StallF) begin
               take_buf     = buf_valid;
               buf_valid_nx = 1'b0;
               state_nx     = S_REQ;
            end
         end
         S_DISCARD: begin
            if (imem.imem_ready) begin
               pcf_nx   = BranchTakenE ? BranchTargetE : redir_pc;
               state_nx = S_REQ;
            end else if (BranchTakenE) begin
               redir_nx = BranchTargetE;
            end
         end
         default: state_nx = S_REQ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_REQ;
         PCF       <= RESET_PC;
         redir_pc  <= 32'd0;
         buf_valid <= 1'b0;
         buf_instr <= 32'd0;
         buf_pc8   <= 32'd0;
         InstrD    <= 32'd0;
         PCPlus8D  <= 32'd0;
         ValidD    <= 1'b0;
      end else begin
         state_q   <= state_nx;
         PCF       <= pcf_nx;
         redir_pc  <= redir_nx;
         buf_valid <= buf_valid_nx;
         if (buf_load) begin
            buf_instr <= imem.imem_rdata;
            buf_pc8   <= PCF + 32'd8;
         end
         if (FlushD) begin
            InstrD <= 32'd0;
            ValidD <= 1'b0;
         end else if (take_mem) begin
            InstrD   <= imem.imem_rdata;
            PCPlus8D <= PCF + 32'd8;
            ValidD   <= 1'b1;
         end else if (take_buf) begin
            InstrD   <= buf_instr;
            PCPlus8D <= buf_pc8;
            ValidD   <= 1'b1;
         end else if (!StallF) begin
            ValidD <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed checks of fetch, wait states, stall,
// redirect, flush, reset and PC wrap.
module tb_ifetch_stage;

   logic        clk;
   logic        reset;
   logic        StallF;
   logic        FlushD;
   logic        BranchTakenE;
   logic [31:0] BranchTargetE;
   logic        ready;
   logic [31:0] PCF;
   logic [31:0] InstrD;
   logic [31:0] PCPlus8D;
   logic        ValidD;

   int n_chk;
   int n_fail;

   ifetch_stage_if bus ();

   // memory image: word at byte address a holds a+1
   assign bus.imem_ready = ready;
   assign bus.imem_rdata = bus.imem_addr + 32'd1;

   ifetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .StallF        (StallF),
      .FlushD        (FlushD),
      .BranchTakenE  (BranchTakenE),
      .BranchTargetE (BranchTargetE),
      .imem          (bus.master),
      .PCF           (PCF),
      .InstrD        (InstrD),
      .PCPlus8D      (PCPlus8D),
      .ValidD        (ValidD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] pc;
      n_chk         = 0;
      n_fail        = 0;
      reset         = 1'b1;
      StallF        = 1'b0;
      FlushD        = 1'b0;
      BranchTakenE  = 1'b0;
      BranchTargetE = 32'd0;
      ready         = 1'b1;

      #3;
      check("rst_pcf", PCF, 32'h0);
      check("rst_valid", {31'd0, ValidD}, 32'd0);
      check("rst_instr", InstrD, 32'd0);
      check("rst_pc8", PCPlus8D, 32'd0);
      check("rst_req", {31'd0, bus.imem_req}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int k = 0; k < 4; k++) begin
         tick();
         check("zw_instr", InstrD, 32'(4 * k + 1));
         check("zw_pc8", PCPlus8D, 32'(4 * k + 8));
         check("zw_valid", {31'd0, ValidD}, 32'd1);
      end

      StallF = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("st_instr", InstrD, 32'h0000_000D);
         check("st_req", {31'd0, bus.imem_req}, 32'd0);
      end
      check("st_pcf", PCF, 32'h14);
      StallF = 1'b0;
      tick();
      check("rel_instr", InstrD, 32'h11);
      check("rel_pc8", PCPlus8D, 32'h18);
      check("rel_addr", bus.imem_addr, 32'h14);
      tick();
      check("rel2_instr", InstrD, 32'h15);
      check("rel2_pc8", PCPlus8D, 32'h1C);

      for (int r = 0; r < 2; r++) begin
         pc    = 32'h18 + 32'(4 * r);
         ready = 1'b0;
         tick();
         check("ws_addr0", bus.imem_addr, pc);
         check("ws_valid0", {31'd0, ValidD}, 32'd0);
         tick();
         check("ws_addr1", bus.imem_addr, pc);
         check("ws_valid1", {31'd0, ValidD}, 32'd0);
         ready = 1'b1;
         tick();
         check("ws_instr", InstrD, pc + 32'd1);
         check("ws_pc8", PCPlus8D, pc + 32'd8);
         check("ws_valid2", {31'd0, ValidD}, 32'd1);
      end

      ready         = 1'b0;
      BranchTakenE  = 1'b1;
      BranchTargetE = 32'h100;
      tick();
      check("br_valid0", {31'd0, ValidD}, 32'd0);
      check("br_addr0", bus.imem_addr, 32'h20);
      BranchTakenE = 1'b0;
      tick();
      check("br_addr1", bus.imem_addr, 32'h20);
      ready = 1'b1;
      tick();
      check("br_drop", InstrD, 32'h1D);
      check("br_valid2", {31'd0, ValidD}, 32'd0);
      check("br_addr2", bus.imem_addr, 32'h100);
      tick();
      check("br_instr", InstrD, 32'h101);
      check("br_pc8", PCPlus8D, 32'h108);
      check("br_valid3", {31'd0, ValidD}, 32'd1);

      FlushD = 1'b1;
      StallF = 1'b1;
      tick();
      check("fl_valid", {31'd0, ValidD}, 32'd0);
      check("fl_instr", InstrD, 32'd0);
      check("fl_addr", bus.imem_addr, 32'h104);
      FlushD = 1'b0;
      StallF = 1'b0;
      tick();
      check("fl_refetch", InstrD, 32'h105);
      check("fl_pc8", PCPlus8D, 32'h10C);

      ready = 1'b0;
      tick();
      check("rw_addr", bus.imem_addr, 32'h108);
      #2;
      reset = 1'b1;
      #1;
      check("rw_pcf", PCF, 32'h0);
      check("rw_valid", {31'd0, ValidD}, 32'd0);
      check("rw_req", {31'd0, bus.imem_req}, 32'd1);
      @(negedge clk);
      reset  = 1'b0;
      ready  = 1'b1;
      StallF = 1'b1;
      tick();
      check("rh_req0", {31'd0, bus.imem_req}, 32'd0);
      check("rh_pcf0", PCF, 32'h4);
      #2;
      reset = 1'b1;
      #1;
      check("rh_pcf", PCF, 32'h0);
      check("rh_valid", {31'd0, ValidD}, 32'd0);
      check("rh_req", {31'd0, bus.imem_req}, 32'd1);
      @(negedge clk);
      reset  = 1'b0;
      StallF = 1'b0;
      tick();
      check("rh_instr", InstrD, 32'h1);
      check("rh_pc8", PCPlus8D, 32'h8);

      BranchTakenE  = 1'b1;
      BranchTargetE = 32'hFFFF_FFFC;
      tick();
      check("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
      check("wr_valid0", {31'd0, ValidD}, 32'd0);
      BranchTakenE = 1'b0;
      tick();
      check("wr_instr", InstrD, 32'hFFFF_FFFD);
      check("wr_pc8", PCPlus8D, 32'h4);
      check("wr_pcf", PCF, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction fetch stage of the pipelined ARM core, directly upstream of the decode stage. Owns the fetch PC, issues word requests to instruction memory over a req/ready handshake, and loads the IF/ID pipeline register (InstrD, PCPlus8D, ValidD) that decode consumes. Handles multi-cycle memory, decode stalls via a one-entry hold buffer, branch redirects (including redirects that arrive while a request is outstanding) and decode flushes.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- StallF  in  1  decode cannot accept; hold IF/ID contents.
- FlushD  in  1  squash IF/ID this cycle (insert bubble).
- BranchTakenE  in  1  redirect fetch to BranchTargetE.
- BranchTargetE  in  32  redirect target, word-aligned.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch word address.
- imem_ready  in  1  memory returns imem_rdata this cycle, completing the request.
- imem_rdata  in  32  instruction word.
- PCF  out  32  current fetch PC.
- InstrD  out  32  IF/ID instruction.
- PCPlus8D  out  32  fetch address of InstrD + 8.
- ValidD  out  1  InstrD holds a real instruction.

## Operation
- State: PCF, RedirPC (32), buffer {BufInstr, BufPC8, BufValid}, IF/ID {InstrD, PCPlus8D, ValidD}, FSM {REQ, HOLD, DISCARD}.
- Reset: PCF=RESET_PC, FSM=REQ, BufValid=0, ValidD=0, InstrD=0, PCPlus8D=0, RedirPC=0.
- imem_req = (FSM != HOLD); imem_addr = PCF. Address stable while imem_req=1 and imem_ready=0.
- Handshake: a request completes on a cycle with imem_req=1 and imem_ready=1; data is sampled that cycle.
- Priority per cycle: BranchTakenE > FlushD > StallF > normal.
- REQ:
  - BranchTakenE and imem_ready: drop data, PCF<=BranchTargetE, BufValid<=0, stay REQ.
  - BranchTakenE and !imem_ready: RedirPC<=BranchTargetE, BufValid<=0, go DISCARD.
  - imem_ready, no redirect, !StallF: IF/ID<={imem_rdata, PCF+8, 1}, PCF<=PCF+4.
  - imem_ready, no redirect, StallF: Buf<={imem_rdata, PCF+8, 1}, PCF<=PCF+4, go HOLD.
  - !imem_ready, !StallF: ValidD<=0 (bubble).
- HOLD (no request issued):
  - BranchTakenE: BufValid<=0, PCF<=BranchTargetE, go REQ.
  - !StallF: IF/ID<=buffer, BufValid<=0, go REQ.
  - StallF: hold everything.
- DISCARD: wait for imem_ready; on it drop data, PCF<=RedirPC, go REQ. A further BranchTakenE in DISCARD overwrites RedirPC (same cycle as imem_ready: PCF<=BranchTargetE).
- On any redirect, IF/ID ValidD<=0 in that cycle unless StallF holds it.
- FlushD (no redirect): ValidD<=0, InstrD<=0 regardless of StallF; the fetch side still advances as if !StallF (buffer is not loaded; returning data is dropped and PCF holds so it is refetched).
- StallF with no other event: IF/ID unchanged.
- PC arithmetic modulo 2^32; PCF+4 from 32'hFFFF_FFFC wraps to 0.

## Timing
- Zero-wait memory (imem_ready tied 1): one instruction per cycle; instruction at PCF appears on InstrD the edge after its request.
- Redirect to first target fetch: target on imem_addr the cycle after BranchTakenE (REQ/HOLD), or the cycle after the outstanding request completes (DISCARD).
- Stall release from HOLD: buffered instruction on InstrD next edge; next request issued in the same cycle as release.
- Reset asynchronous: outputs take reset values immediately, mid-request; outstanding memory data after reset deassertion is treated as a response to RESET_PC.
- No combinational path from imem_rdata to any output.

## Test plan
- Zero-wait, RESET_PC=0, mem[i]=i*4+1: release reset -> InstrD = 1, 5, 9… on consecutive cycles; PCPlus8D = 8, 12, 16; ValidD=1 throughout.
- imem_ready low 2 cycles per request -> imem_addr stable across wait; ValidD pattern 0,0,1 repeating; no skipped/duplicated PCs.
- StallF high 3 cycles when word at 0x10 returns -> InstrD holds prior word; imem_req=0 in HOLD; on release InstrD = mem[0x10], then mem[0x14]; no loss.
- BranchTakenE (target 0x100) while request at 0x20 pending (ready 2 cycles later) -> data for 0x20 never reaches InstrD; next imem_addr=0x100; first valid InstrD = mem[0x100], PCPlus8D=0x108.
- FlushD with StallF together -> ValidD=0, InstrD=0 next edge; subsequent fetch resumes at held PCF with no skipped instruction.
- Reset asserted mid-wait and in HOLD -> PCF=RESET_PC, ValidD=0, imem_req=1 immediately; PCF at 0xFFFF_FFFC advances to 0.
